rtype_pipeline_processor: RTL and testbench

//  Five-stage (fetch/decode/execute/memory/writeback) in-order integer core; parametrised successor of the add-only pipeline.

---
 rtl/rtype_pipeline_processor_pkg.sv | 69 ++++++
 rtl/rtype_pipeline_processor_alu.sv | 36 +++
 rtl/rtype_pipeline_processor.sv | 149 ++++++++++++++
 tb/tb_rtype_pipeline_processor.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtype_pipeline_processor_pkg.sv
// Shared definitions for the five-stage R-format pipeline.
// Contents: instruction field encodings, the ALU operation enum, the
// parameter-independent stage-register structs and the R-format decoder.
package rtype_pipeline_processor_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_t;

    // Fetch/decode latch.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } fetch_reg_t;

    // Control half of the decode/execute latch; operand data lives beside it
    // because its width follows DATA_WIDTH.
    typedef struct packed {
        logic       valid;
        alu_op_t    alu_op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
    } exec_ctrl_t;

    // Returns 1 for a supported R-format word and reports its ALU operation.
    // A non-zero shamt is only meaningful (and only legal) for the shifts.
    function automatic logic rtype_decode(input logic [31:0] instr, output alu_op_t op);
        logic legal;
        logic shamt_zero;
        legal      = 1'b0;
        op         = ALU_ADD;
        shamt_zero = (instr[10:6] == 5'd0);
        if (instr[31:26] == OPCODE_RTYPE) begin
            case (instr[5:0])
                FUNCT_ADD: begin op = ALU_ADD; legal = shamt_zero; end
                FUNCT_SUB: begin op = ALU_SUB; legal = shamt_zero; end
                FUNCT_AND: begin op = ALU_AND; legal = shamt_zero; end
                FUNCT_OR:  begin op = ALU_OR;  legal = shamt_zero; end
                FUNCT_XOR: begin op = ALU_XOR; legal = shamt_zero; end
                FUNCT_SLT: begin op = ALU_SLT; legal = shamt_zero; end
                FUNCT_SLL: begin op = ALU_SLL; legal = 1'b1; end
                FUNCT_SRL: begin op = ALU_SRL; legal = 1'b1; end
                default:   ;
            endcase
        end
        return legal;
    endfunction

endpackage

// File: rtl/rtype_pipeline_processor_alu.sv
// Combinational R-format ALU.
// Ports: alu_op (operation), a (rs operand), b (rt operand),
//        shamt (shift amount), result (DATA_WIDTH result).
// Shifts act on b; a is ignored for them.
module rtype_alu
    import rtype_pipeline_processor_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_op_t               alu_op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [4:0]            shamt,
    output logic [DATA_WIDTH-1:0] result
);

    // Shifting by the full width or more yields zero.
    logic shift_overflow;
    assign shift_overflow = (int'({27'd0, shamt}) >= DATA_WIDTH);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result[0] = ($signed(a) < $signed(b));
            ALU_SLL: result = shift_overflow ? '0 : (b << shamt);
            ALU_SRL: result = shift_overflow ? '0 : (b >> shamt);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rtype_pipeline_processor.sv
// Five-stage in-order R-format core (fetch/decode/execute/memory/writeback).
// Ports:
//   clock, reset (synchronous, active-low)
//   PC / current_instruction / instruction_valid : fetch interface
//   register_file_read_address_1/2, register_file_read_value_1/2 : decode reads
//   register_file_write_value/address/enable : writeback to the external RF
//   illegal_instruction : one-cycle pulse after decode rejects a valid word
//   retired_count : instructions that reached writeback since reset
// Fetch handshake: an instruction is consumed at a rising edge only when
// instruction_valid is 1; with instruction_valid 0 a bubble enters and PC holds.
// Nothing inside the core ever stalls fetch.
module rtype_pipeline_processor
    import rtype_pipeline_processor_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          REG_ADDR_WIDTH = 6,
    parameter logic [31:0] PC_RESET       = 32'h0,
    parameter int          RETIRE_WIDTH   = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic [31:0]               PC,
    input  logic [31:0]               current_instruction,
    input  logic                      instruction_valid,
    output logic [REG_ADDR_WIDTH-1:0] register_file_read_address_1,
    output logic [REG_ADDR_WIDTH-1:0] register_file_read_address_2,
    input  logic [DATA_WIDTH-1:0]     register_file_read_value_1,
    input  logic [DATA_WIDTH-1:0]     register_file_read_value_2,
    output logic [DATA_WIDTH-1:0]     register_file_write_value,
    output logic [REG_ADDR_WIDTH-1:0] register_file_write_address,
    output logic                      register_file_write_enable,
    output logic                      illegal_instruction,
    output logic [RETIRE_WIDTH-1:0]   retired_count
);

    // Stage registers
    fetch_reg_t            if_id;
    exec_ctrl_t            id_ex;
    logic [DATA_WIDTH-1:0] id_ex_a, id_ex_b;
    logic                  ex_mem_valid;
    logic [4:0]            ex_mem_rd;
    logic [DATA_WIDTH-1:0] ex_mem_result;
    logic                  mem_wb_valid;
    logic [4:0]            mem_wb_rd;
    logic [DATA_WIDTH-1:0] mem_wb_result;

    // Decode
    logic [4:0]            dec_rs, dec_rt, dec_rd, dec_shamt;
    alu_op_t               dec_op;
    logic                  dec_legal;
    logic [DATA_WIDTH-1:0] dec_a, dec_b;
    logic                  wb_write;

    assign dec_rs    = if_id.instr[25:21];
    assign dec_rt    = if_id.instr[20:16];
    assign dec_rd    = if_id.instr[15:11];
    assign dec_shamt = if_id.instr[10:6];

    always_comb begin
        dec_op    = ALU_ADD;
        dec_legal = rtype_decode(if_id.instr, dec_op);
    end

    assign register_file_read_address_1 = REG_ADDR_WIDTH'(dec_rs);
    assign register_file_read_address_2 = REG_ADDR_WIDTH'(dec_rt);

    // r0 is never written, so a writeback to it must not retire as a write.
    assign wb_write = mem_wb_valid && (mem_wb_rd != 5'd0);

    // The RF is not write-through: a read of the register being written back
    // this cycle takes the writeback value directly.
    assign dec_a = (wb_write && (mem_wb_rd == dec_rs)) ? mem_wb_result : register_file_read_value_1;
    assign dec_b = (wb_write && (mem_wb_rd == dec_rt)) ? mem_wb_result : register_file_read_value_2;

    // Execute: youngest producer wins, so EX/MEM is checked before MEM/WB.
    logic                  fwd_ex_a, fwd_ex_b, fwd_wb_a, fwd_wb_b;
    logic [DATA_WIDTH-1:0] ex_a, ex_b, alu_result;

    assign fwd_ex_a = ex_mem_valid && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex.rs);
    assign fwd_ex_b = ex_mem_valid && (ex_mem_rd != 5'd0) && (ex_mem_rd == id_ex.rt);
    assign fwd_wb_a = mem_wb_valid && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex.rs);
    assign fwd_wb_b = mem_wb_valid && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex.rt);

    assign ex_a = fwd_ex_a ? ex_mem_result : (fwd_wb_a ? mem_wb_result : id_ex_a);
    assign ex_b = fwd_ex_b ? ex_mem_result : (fwd_wb_b ? mem_wb_result : id_ex_b);

    rtype_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .alu_op (id_ex.alu_op),
        .a      (ex_a),
        .b      (ex_b),
        .shamt  (id_ex.shamt),
        .result (alu_result)
    );

    // Writeback
    assign register_file_write_value   = mem_wb_result;
    assign register_file_write_address = REG_ADDR_WIDTH'(mem_wb_rd);
    assign register_file_write_enable  = wb_write;

    always_ff @(posedge clock) begin
        if (!reset) begin
            PC                  <= PC_RESET;
            if_id               <= '0;
            id_ex               <= '0;
            id_ex_a             <= '0;
            id_ex_b             <= '0;
            ex_mem_valid        <= 1'b0;
            ex_mem_rd           <= '0;
            ex_mem_result       <= '0;
            mem_wb_valid        <= 1'b0;
            mem_wb_rd           <= '0;
            mem_wb_result       <= '0;
            illegal_instruction <= 1'b0;
            retired_count       <= '0;
        end else begin
            // Fetch
            if_id.valid <= instruction_valid;
            if (instruction_valid) begin
                if_id.instr <= current_instruction;
                PC          <= PC + 32'd4;
            end

            // Decode -> execute; an illegal word becomes a bubble.
            id_ex.valid         <= if_id.valid && dec_legal;
            id_ex.alu_op        <= dec_op;
            id_ex.rs            <= dec_rs;
            id_ex.rt            <= dec_rt;
            id_ex.rd            <= dec_rd;
            id_ex.shamt         <= dec_shamt;
            id_ex_a             <= dec_a;
            id_ex_b             <= dec_b;
            illegal_instruction <= if_id.valid && !dec_legal;

            // Execute -> memory
            ex_mem_valid  <= id_ex.valid;
            ex_mem_rd     <= id_ex.rd;
            ex_mem_result <= alu_result;

            // Memory (pass-through) -> writeback
            mem_wb_valid  <= ex_mem_valid;
            mem_wb_rd     <= ex_mem_rd;
            mem_wb_result <= ex_mem_result;

            // Every instruction reaching writeback retires, r0 targets included.
            if (mem_wb_valid) retired_count <= retired_count + RETIRE_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rtype_pipeline_processor.sv
module tb_rtype_pipeline_processor;

  localparam int MAXC = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC;
  logic [31:0] current_instruction = '0;
  logic        instruction_valid = 1'b0;
  logic [5:0]  register_file_read_address_1, register_file_read_address_2;
  logic [31:0] register_file_read_value_1, register_file_read_value_2;
  logic [31:0] register_file_write_value;
  logic [5:0]  register_file_write_address;
  logic        register_file_write_enable;
  logic        illegal_instruction;
  logic [31:0] retired_count;

  rtype_pipeline_processor dut (
    .clock                        (clock),
    .reset                        (reset),
    .PC                           (PC),
    .current_instruction          (current_instruction),
    .instruction_valid            (instruction_valid),
    .register_file_read_address_1 (register_file_read_address_1),
    .register_file_read_address_2 (register_file_read_address_2),
    .register_file_read_value_1   (register_file_read_value_1),
    .register_file_read_value_2   (register_file_read_value_2),
    .register_file_write_value    (register_file_write_value),
    .register_file_write_address  (register_file_write_address),
    .register_file_write_enable   (register_file_write_enable),
    .illegal_instruction          (illegal_instruction),
    .retired_count                (retired_count)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- external register file ----------------
  logic [31:0] rf [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic [31:0] pl_val = '0;

  initial for (int i = 0; i < 64; i++) rf[i] = '0;
  assign register_file_read_value_1 = rf[register_file_read_address_1];
  assign register_file_read_value_2 = rf[register_file_read_address_2];

  always @(posedge clock) begin
    if (register_file_write_enable) rf[register_file_write_address] <= register_file_write_value;
    if (pl_en) rf[pl_addr] <= pl_val;
  end

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- architectural reference model ----------------
  // Instructions execute in program order when fetched; their visible effects
  // are scheduled by the documented latency: illegal pulse 1 window after the
  // fetch edge, write strobe 3 windows after, retirement 4 windows after.
  logic [31:0] model_rf [32];
  logic [31:0] committed [32];
  bit          exp_we  [MAXC];
  bit   [4:0]  exp_addr[MAXC];
  bit   [31:0] exp_val [MAXC];
  bit          exp_ill [MAXC];
  bit          exp_inc [MAXC];
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_ret = '0;
  int          cyc = 0;
  bit          armed = 0;
  logic [5:0]  funct_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02};

  initial for (int i = 0; i < 32; i++) begin model_rf[i] = '0; committed[i] = '0; end

  task automatic iss(input logic [31:0] w, output bit legal, output logic [4:0] rd, output logic [31:0] val);
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [31:0] a, b;
    op = w[31:26]; fn = w[5:0]; sh = w[10:6]; rd = w[15:11];
    a = model_rf[w[25:21]]; b = model_rf[w[20:16]];
    legal = 1; val = '0;
    if (op != 6'h00) legal = 0;
    else case (fn)
      6'h20: val = a + b;
      6'h22: val = a - b;
      6'h24: val = a & b;
      6'h25: val = a | b;
      6'h26: val = a ^ b;
      6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00: val = b << sh;
      6'h02: val = b >> sh;
      default: legal = 0;
    endcase
    if (legal && sh != 0 && fn != 6'h00 && fn != 6'h02) legal = 0;
  endtask

  always @(posedge clock) begin
    bit          lg;
    logic [4:0]  rd;
    logic [31:0] v;
    int          k;
    cyc = cyc + 1;
    k = cyc;
    if (exp_we[k-1]) committed[exp_addr[k-1]] = exp_val[k-1];
    if (!reset) begin
      for (int j = k; j < k + 6; j++) begin
        exp_we[j] = 0; exp_ill[j] = 0; exp_inc[j] = 0;
      end
      for (int i = 0; i < 32; i++) model_rf[i] = committed[i];
      exp_pc = 32'h0;
      exp_ret = '0;
      armed = 1;
    end else begin
      if (exp_inc[k]) exp_ret = exp_ret + 32'd1;
      if (instruction_valid) begin
        iss(current_instruction, lg, rd, v);
        if (lg) begin
          exp_inc[k+4] = 1;
          if (rd != 0) begin
            exp_we[k+3] = 1; exp_addr[k+3] = rd; exp_val[k+3] = v;
            model_rf[rd] = v;
          end
        end else exp_ill[k+1] = 1;
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  // ---------------- compare process + observation log ----------------
  logic [5:0]  log_addr[$];
  logic [31:0] log_val[$];
  int          log_win[$];
  int          ill_seen = 0;

  always @(negedge clock) begin
    if (armed) begin
      check("pc", PC, exp_pc);
      check("write_enable", {31'd0, register_file_write_enable}, {31'd0, exp_we[cyc]});
      if (exp_we[cyc]) begin
        check("write_address", {26'd0, register_file_write_address}, {27'd0, exp_addr[cyc]});
        check("write_value", register_file_write_value, exp_val[cyc]);
      end
      check("illegal", {31'd0, illegal_instruction}, {31'd0, exp_ill[cyc]});
      check("retired", retired_count, exp_ret);
      if (register_file_write_enable) begin
        log_addr.push_back(register_file_write_address);
        log_val.push_back(register_file_write_value);
        log_win.push_back(cyc);
      end
      if (illegal_instruction) ill_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc(input logic [5:0] fn, input int rd, input int rs, input int rt, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  task automatic issue(input logic [31:0] w);
    @(negedge clock);
    pl_en = 0;
    instruction_valid = 1;
    current_instruction = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      pl_en = 0;
      instruction_valid = 0;
      current_instruction = $urandom;
    end
  endtask

  task automatic preload(input int r, input logic [31:0] v);
    @(negedge clock);
    instruction_valid = 0;
    pl_en = 1; pl_addr = 6'(r); pl_val = v;
    model_rf[r] = v;
    committed[r] = v;
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clock);
      pl_en = 0;
      reset = 0;
      instruction_valid = 1'($urandom);
      current_instruction = $urandom;
    end
    @(negedge clock);
    reset = 1;
    instruction_valid = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    int r;
    int f;
    r = $urandom_range(0, 99);
    if (r < 4) return {6'($urandom_range(1, 63)), 26'($urandom)};
    if (r < 7) return enc(6'h21, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
    if (r < 9) return enc(6'h20, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 31));
    f = $urandom_range(0, 7);
    return enc(funct_tab[f], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               (f >= 6) ? $urandom_range(0, 31) : 0);
  endfunction

  // ---------------- main sequence ----------------
  int          n0;
  logic [31:0] pc0, ret0;
  int          ill0;

  initial begin
    // Reset held 3 cycles with random fetch traffic.
    do_reset(3);
    check("reset_pc", PC, 32'h0);
    check("reset_ret", retired_count, 32'd0);

    // Forwarding chain.
    preload(1, 32'd5);
    preload(2, 32'd7);
    issue(enc(6'h20, 3, 1, 2, 0));
    issue(enc(6'h22, 4, 3, 1, 0));
    issue(enc(6'h20, 5, 4, 3, 0));
    idle(6);
    n0 = log_addr.size();
    if (n0 >= 3) begin
      check("fwd_r3_addr", {26'd0, log_addr[n0-3]}, 32'd3);
      check("fwd_r3_val", log_val[n0-3], 32'd12);
      check("fwd_r4_val", log_val[n0-2], 32'd7);
      check("fwd_r5_addr", {26'd0, log_addr[n0-1]}, 32'd5);
      check("fwd_r5_val", log_val[n0-1], 32'd19);
      check("fwd_consecutive", 32'(log_win[n0-1] - log_win[n0-3]), 32'd2);
    end else check("fwd_write_count", 32'(n0), 32'd3);
    check("model_r5", model_rf[5], 32'd19);

    // Operations and wrap.
    preload(1, 32'hFFFF_FFFF);
    preload(2, 32'd1);
    n0 = log_addr.size();
    issue(enc(6'h20, 6, 1, 2, 0));
    issue(enc(6'h2A, 7, 1, 2, 0));
    issue(enc(6'h00, 8, 0, 2, 31));
    issue(enc(6'h02, 9, 0, 1, 4));
    issue(enc(6'h26, 10, 1, 2, 0));
    idle(6);
    check("ops_count", 32'(log_addr.size() - n0), 32'd5);
    if (log_addr.size() - n0 == 5) begin
      check("op_add_wrap", log_val[n0], 32'h0);
      check("op_slt", log_val[n0+1], 32'h1);
      check("op_sll31", log_val[n0+2], 32'h8000_0000);
      check("op_srl4", log_val[n0+3], 32'h0FFF_FFFF);
      check("op_xor", log_val[n0+4], 32'hFFFF_FFFE);
    end

    // Fetch handshake with a 2-cycle gap.
    preload(1, 32'd5);
    preload(2, 32'd7);
    @(negedge clock);
    pl_en = 0;
    pc0 = PC; ret0 = retired_count;
    instruction_valid = 1; current_instruction = enc(6'h20, 3, 1, 2, 0);
    issue(enc(6'h24, 4, 3, 2, 0));
    idle(2);
    issue(enc(6'h25, 5, 4, 1, 0));
    issue(enc(6'h22, 6, 5, 3, 0));
    idle(6);
    check("hs_pc_delta", PC - pc0, 32'd16);
    check("hs_ret_delta", retired_count - ret0, 32'd4);

    // Illegal word and r0 destination.
    ill0 = ill_seen;
    n0 = log_addr.size();
    ret0 = retired_count;
    issue(32'h8C22_0000);
    issue(enc(6'h20, 0, 1, 2, 0));
    idle(6);
    check("ill_pulses", 32'(ill_seen - ill0), 32'd1);
    check("ill_r0_no_write", 32'(log_addr.size() - n0), 32'd0);
    check("ill_r0_retired", retired_count - ret0, 32'd1);
    preload(11, 32'd99);
    issue(enc(6'h20, 11, 0, 0, 0));
    idle(6);
    check("r0_read_addr", {26'd0, log_addr[log_addr.size()-1]}, 32'd11);
    check("r0_read_val", log_val[log_val.size()-1], 32'd0);

    // Reset with three instructions in flight.
    preload(1, 32'd3);
    preload(2, 32'd4);
    n0 = log_addr.size();
    issue(enc(6'h20, 12, 1, 2, 0));
    issue(enc(6'h20, 13, 1, 2, 0));
    issue(enc(6'h20, 14, 1, 2, 0));
    do_reset(2);
    idle(6);
    check("rst_mid_no_write", 32'(log_addr.size() - n0), 32'd0);
    check("rst_mid_pc", PC, 32'h0);
    issue(enc(6'h20, 12, 1, 2, 0));
    idle(6);
    check("restart_addr", {26'd0, log_addr[log_addr.size()-1]}, 32'd12);
    check("restart_val", log_val[log_val.size()-1], 32'd7);
    check("restart_ret", retired_count, 32'd1);

    // Random traffic with dense hazards over r0..r7.
    for (int i = 1; i < 8; i++) preload(i, $urandom);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(2);
      if ($urandom_range(0, 9) < 8) issue(rand_instr());
      else idle(1);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
